// File: rtl/mclock_stretch_if.sv
// Memory-side bus of the clock stretcher: CPU address/controls in, stretched
// memory clock and status out.
interface mclock_stretch_if #(
  parameter int ADDR_W = 32,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] address;
  logic              stretch_en;
  logic [WAIT_W-1:0] wait_cycles;
  logic              mem_ready;
  logic              mclk;
  logic              busy;
  logic              timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output address, stretch_en, wait_cycles, mem_ready,
    input  mclk, busy, timeout, stall_cycles
  );

  modport slave (
    input  address, stretch_en, wait_cycles, mem_ready,
    output mclk, busy, timeout, stall_cycles
  );
endinterface

// File: rtl/mclock_stretch.sv
// Memory clock generator: holds mclk high for a programmable number of core
// cycles after each address change, optionally extended until mem_ready.
module mclock_stretch #(
  parameter int ADDR_W  = 32,
  parameter int WAIT_W  = 4,
  parameter int EXT_MAX = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  mclock_stretch_if.slave  bus
);

  localparam int ECNT_W = $clog2(EXT_MAX) + 1;
  localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(EXT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXTEND
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WAIT_W-1:0] wcnt_reg;
  logic [ECNT_W-1:0] ecnt_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  stall_reg;

  logic start;
  logic hold;

  assign start = (state_reg == ST_IDLE) && bus.stretch_en &&
                 (bus.address != addr_reg) && (bus.wait_cycles != '0);

  // Gated by reset so mclk tracks clk for the whole reset interval, even if
  // the address already differs from the cleared latch.
  assign hold = reset && (start || (state_reg != ST_IDLE));

  // hold only moves while clk is high, so the OR cannot glitch.
  assign bus.mclk         = clk | hold;
  assign bus.busy         = hold;
  assign bus.timeout      = timeout_reg;
  assign bus.stall_cycles = stall_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wcnt_reg    <= '0;
      ecnt_reg    <= '0;
      timeout_reg <= 1'b0;
      stall_reg   <= '0;
    end else begin
      timeout_reg <= 1'b0;

      if (hold && (stall_reg != CNT_MAX)) begin
        stall_reg <= stall_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          // Always tracking the address in IDLE means re-enabling never
          // finds a stale mismatch.
          addr_reg <= bus.address;
          if (start) begin
            if (bus.wait_cycles == WAIT_ONE) begin
              if (!bus.mem_ready) begin
                state_reg <= ST_EXTEND;
                ecnt_reg  <= '0;
              end
            end else begin
              wcnt_reg  <= bus.wait_cycles - WAIT_ONE;
              state_reg <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (wcnt_reg > WAIT_ONE) begin
            wcnt_reg <= wcnt_reg - WAIT_ONE;
          end else if (bus.mem_ready) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_EXTEND;
            ecnt_reg  <= '0;
          end
        end

        ST_EXTEND: begin
          if (bus.mem_ready) begin
            state_reg <= ST_IDLE;
          end else if (ecnt_reg == ECNT_LAST) begin
            state_reg   <= ST_IDLE;
            timeout_reg <= 1'b1;
          end else begin
            ecnt_reg <= ecnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mclock_stretch.sv
// Directed bench for mclock_stretch: counts missing mclk rising edges against
// clk rising edges and checks status outputs against hand-computed values.
module tb_mclock_stretch;

  localparam int ADDR_W  = 32;
  localparam int WAIT_W  = 4;
  localparam int EXT_MAX = 16;
  localparam int CNT_W   = 16;

  logic clk;
  logic reset;

  mclock_stretch_if #(.ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) bus_if ();

  mclock_stretch #(
    .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .EXT_MAX(EXT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int clk_edges = 0;
  int mclk_edges = 0;
  int to_cnt = 0;

  always @(posedge clk) clk_edges++;
  always @(posedge bus_if.mclk) mclk_edges++;
  always @(negedge clk) if (bus_if.timeout === 1'b1) to_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Land just after a rising edge, while clk is high, to drive inputs.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  int c0, m0, st0, t0;

  function automatic int suppressed();
    return (clk_edges - c0) - (mclk_edges - m0);
  endfunction

  task automatic snap();
    c0  = clk_edges;
    m0  = mclk_edges;
    st0 = int'(bus_if.stall_cycles);
    t0  = to_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus_if.address     = 32'h100;
    bus_if.stretch_en  = 1'b1;
    bus_if.wait_cycles = 4'd2;
    bus_if.mem_ready   = 1'b1;

    // Reset: mclk follows clk, nothing busy.
    repeat (4) @(negedge clk);
    check("rst_mclk_lo", bus_if.mclk, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_stall", bus_if.stall_cycles, 0);
    check("rst_timeout", bus_if.timeout, 0);
    next_edge();
    check("rst_mclk_hi", bus_if.mclk, 1);
    reset = 1'b1;
    snap();
    #1;
    check("rel_busy", bus_if.busy, 1);
    repeat (5) @(negedge clk);
    check("rel_supp", suppressed(), 2);
    check("rel_stall", bus_if.stall_cycles, 2);
    check("rel_busy_end", bus_if.busy, 0);
    $display("txn reset_release: suppressed=%0d stall=%0d", suppressed(), bus_if.stall_cycles);

    // wait_cycles=3, ready memory: 0x0 -> 0x40.
    next_edge();
    bus_if.stretch_en = 1'b0;
    bus_if.address    = 32'h0;
    next_edge();
    bus_if.stretch_en = 1'b1;
    snap();
    next_edge();
    bus_if.address     = 32'h40;
    bus_if.wait_cycles = 4'd3;
    #1;
    check("w3_busy_start", bus_if.busy, 1);
    repeat (6) @(negedge clk);
    check("w3_supp", suppressed(), 3);
    check("w3_stall", int'(bus_if.stall_cycles) - st0, 3);
    check("w3_busy_end", bus_if.busy, 0);
    $display("txn wait3: suppressed=%0d", suppressed());

    // wait_cycles=1, mem_ready low on 4 edges: 5 suppressed, no timeout.
    next_edge();
    bus_if.address     = 32'h80;
    bus_if.wait_cycles = 4'd1;
    bus_if.mem_ready   = 1'b0;
    snap();
    repeat (4) @(posedge clk);
    #1;
    bus_if.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ext_supp", suppressed(), 5);
    check("ext_stall", int'(bus_if.stall_cycles) - st0, 5);
    check("ext_no_timeout", to_cnt - t0, 0);
    check("ext_busy_end", bus_if.busy, 0);
    $display("txn extend4: suppressed=%0d", suppressed());

    // wait_cycles=2, mem_ready stuck low: 2 + EXT_MAX then timeout pulse.
    next_edge();
    bus_if.address     = 32'hC0;
    bus_if.wait_cycles = 4'd2;
    bus_if.mem_ready   = 1'b0;
    snap();
    repeat (2 + EXT_MAX) @(posedge clk);
    @(negedge clk);
    check("to_pulse", bus_if.timeout, 1);
    check("to_busy", bus_if.busy, 0);
    @(negedge clk);
    check("to_clear", bus_if.timeout, 0);
    repeat (3) @(negedge clk);
    check("to_supp", suppressed(), 2 + EXT_MAX);
    check("to_stall", int'(bus_if.stall_cycles) - st0, 2 + EXT_MAX);
    check("to_count", to_cnt - t0, 1);
    $display("txn timeout: suppressed=%0d pulses=%0d", suppressed(), to_cnt - t0);

    // Disabled changes never stall, re-enable with steady address is quiet.
    next_edge();
    bus_if.mem_ready  = 1'b1;
    bus_if.stretch_en = 1'b0;
    bus_if.address    = 32'h10;
    snap();
    next_edge();
    bus_if.address = 32'h20;
    next_edge();
    next_edge();
    bus_if.stretch_en = 1'b1;
    next_edge();
    next_edge();
    @(negedge clk);
    check("dis_supp", suppressed(), 0);
    check("dis_busy", bus_if.busy, 0);
    next_edge();
    bus_if.address = 32'h24;
    snap();
    repeat (4) @(negedge clk);
    check("reen_supp", suppressed(), 2);
    $display("txn disable_reenable: suppressed=%0d", suppressed());

    // Reset mid-stall aborts; then a back-to-back pair of stalls.
    next_edge();
    bus_if.address     = 32'h200;
    bus_if.wait_cycles = 4'd4;
    next_edge();
    check("mid_busy_pre", bus_if.busy, 1);
    reset = 1'b0;
    #1;
    check("mid_busy_rst", bus_if.busy, 0);
    @(negedge clk);
    check("mid_mclk_rst", bus_if.mclk, 0);
    check("mid_stall_rst", bus_if.stall_cycles, 0);
    next_edge();
    reset = 1'b1;
    snap();
    next_edge();
    bus_if.address = 32'h300;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_busy", bus_if.busy, 1);
    repeat (5) @(negedge clk);
    check("b2b_supp", suppressed(), 8);
    check("b2b_stall", bus_if.stall_cycles, 8);
    check("b2b_busy_end", bus_if.busy, 0);
    $display("txn back_to_back: suppressed=%0d stall=%0d", suppressed(), bus_if.stall_cycles);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
